// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared encodings and helpers for the MEM stage.
//   - access size encodings (byte / half / word; 2'b10 decodes as word)
//   - datapath defaults
//   - byte-enable and misalignment helpers for a 32-bit, 4-lane word
package mem_stage_pkg;

  localparam int BITS_SIZE_DEF = 32;
  localparam int BITS_REGS_DEF = 5;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'b00,
    MEM_SIZE_HALF = 2'b01,
    MEM_SIZE_WORD = 2'b11
  } mem_size_e;

  // Lane enables for a store. Half ignores lo[0] and word ignores lo entirely,
  // so unaligned addresses are forced aligned here.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      MEM_SIZE_BYTE: return 4'b0001 << lo;
      MEM_SIZE_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      default:       return 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      MEM_SIZE_BYTE: return 1'b0;
      MEM_SIZE_HALF: return lo[0];
      default:       return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// data_memory: word-organised data RAM for the MEM stage.
//   gclk      in   clock (write port)
//   we        in   write enable
//   be        in   [3:0] byte-lane enables, lane 0 = bits [7:0]
//   addr      in   word index shared by the read and write ports
//   wdata     in   lane-replicated write data
//   rdata     out  asynchronous read of mem[addr]
//   dbg_addr  in   debug word index
//   dbg_data  out  asynchronous read of mem[dbg_addr]
// Contents are never reset.
module data_memory #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              gclk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge gclk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata    = mem[addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage.
//   EX/MEM register -> data memory access (async read, byte-enable sync write)
//   -> MEM/WB register. EX/MEM and MEM/WB values are exported for forwarding.
// Ports:
//   i_clk, i_reset (sync, active-low), i_stall (hold both regs, no write),
//   i_flush (bubble into EX/MEM), i_ex_* (EX results/controls),
//   o_exmem_* (forwarding), o_memwb_* (to WB), i_dbg_addr/o_dbg_data (debug read),
//   o_misalign (sticky misaligned-access flag).
// Build option: MEM_ALIGN_CHECK_EN -- when defined, misaligned stores are dropped,
// misaligned loads return 0 and o_misalign latches; otherwise low address bits are
// forced aligned and o_misalign is 0.
// The memory is 4 byte lanes wide, so BITS_SIZE must stay 32.
module mem_stage import mem_stage_pkg::*; #(
  parameter  int BITS_SIZE = BITS_SIZE_DEF,
  parameter  int BITS_REGS = BITS_REGS_DEF,
  parameter  int MEM_DEPTH = 64,
  localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic [BITS_SIZE-1:0] i_ex_alu_result,
  input  logic [BITS_SIZE-1:0] i_ex_store_data,
  input  logic [BITS_REGS-1:0] i_ex_rd,
  input  logic                 i_ex_mem_read,
  input  logic                 i_ex_mem_write,
  input  logic [1:0]           i_ex_mem_size,
  input  logic                 i_ex_mem_unsigned,
  input  logic                 i_ex_reg_write,
  input  logic                 i_ex_mem_to_reg,
  input  logic [ADDR_W-1:0]    i_dbg_addr,
  output logic [BITS_SIZE-1:0] o_exmem_alu_result,
  output logic [BITS_REGS-1:0] o_exmem_rd,
  output logic                 o_exmem_reg_write,
  output logic [BITS_SIZE-1:0] o_memwb_load_data,
  output logic [BITS_SIZE-1:0] o_memwb_alu_result,
  output logic [BITS_REGS-1:0] o_memwb_rd,
  output logic                 o_memwb_reg_write,
  output logic                 o_memwb_mem_to_reg,
  output logic [BITS_SIZE-1:0] o_dbg_data,
  output logic                 o_misalign
);

  // EX/MEM
  logic [BITS_SIZE-1:0] exmem_alu, exmem_sd;
  logic [BITS_REGS-1:0] exmem_rd;
  logic                 exmem_rd_en, exmem_wr_en, exmem_uns, exmem_rw, exmem_m2r;
  logic [1:0]           exmem_size;

  // Flush takes priority over stall so a killed instruction never lingers.
  always_ff @(posedge i_clk) begin
    if (!i_reset || i_flush) begin
      exmem_alu   <= '0;
      exmem_sd    <= '0;
      exmem_rd    <= '0;
      exmem_rd_en <= 1'b0;
      exmem_wr_en <= 1'b0;
      exmem_size  <= '0;
      exmem_uns   <= 1'b0;
      exmem_rw    <= 1'b0;
      exmem_m2r   <= 1'b0;
    end else if (!i_stall) begin
      exmem_alu   <= i_ex_alu_result;
      exmem_sd    <= i_ex_store_data;
      exmem_rd    <= i_ex_rd;
      exmem_rd_en <= i_ex_mem_read;
      exmem_wr_en <= i_ex_mem_write;
      exmem_size  <= i_ex_mem_size;
      exmem_uns   <= i_ex_mem_unsigned;
      exmem_rw    <= i_ex_reg_write;
      exmem_m2r   <= i_ex_mem_to_reg;
    end
  end

  // Memory access
  logic [1:0]        lo;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       rdata, wdata;
  logic [3:0]        be;
  logic              we, mis;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       ext, load_val;

  assign lo       = exmem_alu[1:0];
  assign word_idx = exmem_alu[ADDR_W+1:2];
  assign be       = byte_en(exmem_size, lo);

`ifdef MEM_ALIGN_CHECK_EN
  assign mis = (exmem_rd_en || exmem_wr_en) && is_misaligned(exmem_size, lo);
`else
  assign mis = 1'b0;
`endif

  // Store commits on the first non-stalled, non-reset edge after capture.
  assign we = i_reset && !i_stall && exmem_wr_en && !mis;

  always_comb begin
    wdata = exmem_sd;
    case (exmem_size)
      MEM_SIZE_BYTE: wdata = {4{exmem_sd[7:0]}};
      MEM_SIZE_HALF: wdata = {2{exmem_sd[15:0]}};
      default:       wdata = exmem_sd;
    endcase
  end

  data_memory #(.DEPTH(MEM_DEPTH)) u_dmem (
    .gclk     (i_clk),
    .we       (we),
    .be       (be),
    .addr     (word_idx),
    .wdata    (wdata),
    .rdata    (rdata),
    .dbg_addr (i_dbg_addr),
    .dbg_data (o_dbg_data)
  );

  assign byte_v = rdata[{lo, 3'b000} +: 8];
  assign half_v = lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ext = rdata;
    case (exmem_size)
      MEM_SIZE_BYTE: ext = exmem_uns ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      MEM_SIZE_HALF: ext = exmem_uns ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      default:       ext = rdata;
    endcase
  end

  assign load_val = (exmem_rd_en && !mis) ? ext : '0;

  // MEM/WB
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_memwb_load_data  <= '0;
      o_memwb_alu_result <= '0;
      o_memwb_rd         <= '0;
      o_memwb_reg_write  <= 1'b0;
      o_memwb_mem_to_reg <= 1'b0;
    end else if (!i_stall) begin
      o_memwb_load_data  <= load_val;
      o_memwb_alu_result <= exmem_alu;
      o_memwb_rd         <= exmem_rd;
      o_memwb_reg_write  <= exmem_rw;
      o_memwb_mem_to_reg <= exmem_m2r;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset)               o_misalign <= 1'b0;
    else if (!i_stall && mis)   o_misalign <= 1'b1;
  end
`else
  assign o_misalign = 1'b0;
`endif

  assign o_exmem_alu_result = exmem_alu;
  assign o_exmem_rd         = exmem_rd;
  assign o_exmem_reg_write  = exmem_rw;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic [31:0] alu = '0, sd = '0;
  logic [4:0]  rd = '0;
  logic        mrd = 1'b0, mwr = 1'b0, uns = 1'b0, rw = 1'b0, m2r = 1'b0;
  logic [1:0]  sz = 2'b11;
  logic [5:0]  dbg_addr = '0;
  logic [31:0] exmem_alu, memwb_ld, memwb_alu, dbg_data;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_rw, memwb_rw, memwb_m2r, misalign;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .i_clk              (clk),
    .i_reset            (rst),
    .i_stall            (stall),
    .i_flush            (flush),
    .i_ex_alu_result    (alu),
    .i_ex_store_data    (sd),
    .i_ex_rd            (rd),
    .i_ex_mem_read      (mrd),
    .i_ex_mem_write     (mwr),
    .i_ex_mem_size      (sz),
    .i_ex_mem_unsigned  (uns),
    .i_ex_reg_write     (rw),
    .i_ex_mem_to_reg    (m2r),
    .i_dbg_addr         (dbg_addr),
    .o_exmem_alu_result (exmem_alu),
    .o_exmem_rd         (exmem_rd),
    .o_exmem_reg_write  (exmem_rw),
    .o_memwb_load_data  (memwb_ld),
    .o_memwb_alu_result (memwb_alu),
    .o_memwb_rd         (memwb_rd),
    .o_memwb_reg_write  (memwb_rw),
    .o_memwb_mem_to_reg (memwb_m2r),
    .o_dbg_data         (dbg_data),
    .o_misalign         (misalign)
  );

  // Present one instruction, take one edge, settle 1 time unit past it.
  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                       input logic rd_en, input logic wr_en, input logic [1:0] s,
                       input logic u, input logic regw, input logic memtoreg);
    alu = a; sd = d; rd = r; mrd = rd_en; mwr = wr_en; sz = s; uns = u; rw = regw; m2r = memtoreg;
    @(posedge clk); #1;
  endtask

  task automatic nop();
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    total++; if (exmem_alu !== 32'h0) begin bad++; $display("FAIL reset_exmem_alu: got %h want 0", exmem_alu); end
    total++; if (exmem_rd !== 5'd0 || exmem_rw !== 1'b0) begin bad++; $display("FAIL reset_exmem_ctl: got rd=%0d rw=%b want 0", exmem_rd, exmem_rw); end
    total++; if (memwb_ld !== 32'h0 || memwb_alu !== 32'h0) begin bad++; $display("FAIL reset_memwb_data: got ld=%h alu=%h want 0", memwb_ld, memwb_alu); end
    total++; if (memwb_rd !== 5'd0 || memwb_rw !== 1'b0 || memwb_m2r !== 1'b0) begin bad++; $display("FAIL reset_memwb_ctl: got rd=%0d rw=%b m2r=%b want 0", memwb_rd, memwb_rw, memwb_m2r); end
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL reset_misalign: got %b want 0", misalign); end
    rst = 1'b1;
    nop();
  endtask

  task automatic test_word();
    drive(32'h10, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);   // SW
    total++; if (exmem_alu !== 32'h10 || exmem_rw !== 1'b0) begin bad++; $display("FAIL sw_exmem: got alu=%h rw=%b want 10/0", exmem_alu, exmem_rw); end
    drive(32'h10, 32'h0, 5'd3, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1);           // LW r3
    total++; if (exmem_rd !== 5'd3 || exmem_rw !== 1'b1) begin bad++; $display("FAIL lw_exmem_fwd: got rd=%0d rw=%b want 3/1", exmem_rd, exmem_rw); end
    total++; if (memwb_ld !== 32'h0) begin bad++; $display("FAIL sw_no_load_data: got %h want 0", memwb_ld); end
    nop();
    total++; if (memwb_ld !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_word: got %h want deadbeef", memwb_ld); end
    total++; if (memwb_rd !== 5'd3 || memwb_rw !== 1'b1 || memwb_m2r !== 1'b1) begin bad++; $display("FAIL lw_memwb_ctl: got rd=%0d rw=%b m2r=%b want 3/1/1", memwb_rd, memwb_rw, memwb_m2r); end
  endtask

  task automatic test_byte();
    drive(32'h13, 32'h1234_5680, 5'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);   // SB
    drive(32'h13, 32'h0, 5'd4, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);           // LB
    drive(32'h13, 32'h0, 5'd5, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);           // LBU
    total++; if (memwb_ld !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_sign: got %h want ffffff80", memwb_ld); end
    drive(32'h10, 32'h0, 5'd6, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1);           // LW
    total++; if (memwb_ld !== 32'h0000_0080) begin bad++; $display("FAIL lbu_zero: got %h want 00000080", memwb_ld); end
    nop();
    total++; if (memwb_ld !== 32'h80AD_BEEF) begin bad++; $display("FAIL sb_lane3_word: got %h want 80adbeef", memwb_ld); end
    total++; if (memwb_alu !== 32'h10 || memwb_rd !== 5'd6) begin bad++; $display("FAIL memwb_pass: got alu=%h rd=%0d want 10/6", memwb_alu, memwb_rd); end
  endtask

  task automatic test_half();
    drive(32'h22, 32'hABCD_1234, 5'd0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);   // SH upper
    drive(32'h20, 32'h0000_8001, 5'd0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);   // SH lower
    drive(32'h22, 32'h0, 5'd1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1);           // LH 0x22
    drive(32'h20, 32'h0, 5'd1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1);           // LH 0x20
    total++; if (memwb_ld !== 32'h0000_1234) begin bad++; $display("FAIL lh_upper: got %h want 00001234", memwb_ld); end
    drive(32'h20, 32'h0, 5'd1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1);           // LHU 0x20
    total++; if (memwb_ld !== 32'hFFFF_8001) begin bad++; $display("FAIL lh_sign: got %h want ffff8001", memwb_ld); end
    drive(32'h23, 32'h0, 5'd1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1);           // LH 0x23 (odd)
    total++; if (memwb_ld !== 32'h0000_8001) begin bad++; $display("FAIL lhu_zero: got %h want 00008001", memwb_ld); end
    drive(32'h20, 32'h0, 5'd1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1);           // LW 0x20
`ifdef MEM_ALIGN_CHECK_EN
    total++; if (memwb_ld !== 32'h0 || misalign !== 1'b1) begin bad++; $display("FAIL lh_misaligned: got ld=%h mis=%b want 0/1", memwb_ld, misalign); end
`else
    total++; if (memwb_ld !== 32'h0000_1234 || misalign !== 1'b0) begin bad++; $display("FAIL lh_odd_forced: got ld=%h mis=%b want 00001234/0", memwb_ld, misalign); end
`endif
    nop();
    total++; if (memwb_ld !== 32'h1234_8001) begin bad++; $display("FAIL sh_both_halves: got %h want 12348001", memwb_ld); end
  endtask

  task automatic test_stall();
    dbg_addr = 6'd12;
    drive(32'h30, 32'h1111_1111, 5'd0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);   // SW seed
    drive(32'h10, 32'h0, 5'd7, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1);           // LW r7
    total++; if (dbg_data !== 32'h1111_1111) begin bad++; $display("FAIL stall_seed: got %h want 11111111", dbg_data); end
    drive(32'h30, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);   // SW to be stalled
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h34, 32'h5555_5555, 5'd9, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0);
      total++; if (dbg_data !== 32'h1111_1111) begin bad++; $display("FAIL stall_no_write[%0d]: got %h want 11111111", i, dbg_data); end
      total++; if (exmem_alu !== 32'h30 || exmem_rw !== 1'b0) begin bad++; $display("FAIL stall_exmem_hold[%0d]: got alu=%h rw=%b want 30/0", i, exmem_alu, exmem_rw); end
      total++; if (memwb_rd !== 5'd7 || memwb_ld !== 32'h80AD_BEEF) begin bad++; $display("FAIL stall_memwb_hold[%0d]: got rd=%0d ld=%h want 7/80adbeef", i, memwb_rd, memwb_ld); end
    end
    stall = 1'b0;
    nop();
    total++; if (dbg_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL stall_release_write: got %h want cafef00d", dbg_data); end
    total++; if (exmem_alu !== 32'h0 || memwb_alu !== 32'h30) begin bad++; $display("FAIL stall_release_adv: got exmem=%h memwb=%h want 0/30", exmem_alu, memwb_alu); end
  endtask

  task automatic test_flush();
    dbg_addr = 6'd16;
    drive(32'h40, 32'h2222_2222, 5'd0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    nop();
    total++; if (dbg_data !== 32'h2222_2222) begin bad++; $display("FAIL flush_seed: got %h want 22222222", dbg_data); end
    flush = 1'b1;
    drive(32'h40, 32'h9999_9999, 5'd9, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0);
    flush = 1'b0;
    total++; if (exmem_rw !== 1'b0 || exmem_alu !== 32'h0 || exmem_rd !== 5'd0) begin bad++; $display("FAIL flush_bubble: got rw=%b alu=%h rd=%0d want 0", exmem_rw, exmem_alu, exmem_rd); end
    nop();
    total++; if (memwb_rw !== 1'b0 || dbg_data !== 32'h2222_2222) begin bad++; $display("FAIL flush_no_effect: got rw=%b mem=%h want 0/22222222", memwb_rw, dbg_data); end
  endtask

  task automatic test_stall_flush();
    drive(32'h10, 32'h0, 5'd10, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1);          // A
    drive(32'h10, 32'h0, 5'd11, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1);          // B
    stall = 1'b1; flush = 1'b1;
    nop();
    stall = 1'b0; flush = 1'b0;
    total++; if (exmem_rd !== 5'd0 || exmem_rw !== 1'b0) begin bad++; $display("FAIL sf_exmem_flushed: got rd=%0d rw=%b want 0/0", exmem_rd, exmem_rw); end
    total++; if (memwb_rd !== 5'd10 || memwb_ld !== 32'h80AD_BEEF) begin bad++; $display("FAIL sf_memwb_hold: got rd=%0d ld=%h want 10/80adbeef", memwb_rd, memwb_ld); end
    nop();
    total++; if (memwb_rw !== 1'b0 || memwb_rd !== 5'd0) begin bad++; $display("FAIL sf_bubble_wb: got rw=%b rd=%0d want 0/0", memwb_rw, memwb_rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_stall();
    test_flush();
    test_stall_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
